// File: rtl/gray_counter_chk_if.sv
// Signal bundle for gray_counter_chk: counter controls/views and the
// Gray monitor channel. master drives the inputs, slave is the block.
interface gray_counter_chk_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic             load_gray;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             wrap;
  logic [WIDTH-1:0] gray_in;
  logic             gray_in_vld;
  logic [WIDTH-1:0] bin_dec;
  logic             bin_dec_vld;
  logic             step_err;

  modport master (
    output en, up_dn, load, load_gray, load_val, gray_in, gray_in_vld,
    input  bin_q, gray_q, wrap, bin_dec, bin_dec_vld, step_err
  );

  modport slave (
    input  en, up_dn, load, load_gray, load_val, gray_in, gray_in_vld,
    output bin_q, gray_q, wrap, bin_dec, bin_dec_vld, step_err
  );
endinterface

// File: rtl/gray_counter_chk.sv
// Gray-code up/down counter with binary/Gray load and wrap pulse, plus an
// independent monitor that decodes Gray samples and flags multi-bit steps.
module gray_counter_chk #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  gray_counter_chk_if.slave bus
);

  logic [WIDTH-1:0] bin_reg;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_reg;
  logic [WIDTH-1:0] gray_next;
  logic             wrap_reg;
  logic             wrap_next;

  logic [WIDTH-1:0] load_dec;
  logic [WIDTH-1:0] in_dec;
  logic [WIDTH-1:0] prev_reg;
  logic             have_prev_reg;
  logic [WIDTH-1:0] dec_reg;
  logic             dec_vld_reg;
  logic             step_err_reg;
  logic [WIDTH-1:0] step_diff;
  logic             multi_bit;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above
  // it. Written as a slice reduction so no bit depends on another output bit.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_g2b
      assign load_dec[gi] = ^bus.load_val[WIDTH-1:gi];
      assign in_dec[gi]   = ^bus.gray_in[WIDTH-1:gi];
    end
  endgenerate

  // Next counter value: load beats count, count beats hold; wrap only on a count.
  always_comb begin
    bin_next  = bin_reg;
    wrap_next = 1'b0;
    if (bus.load) begin
      bin_next = bus.load_gray ? load_dec : bus.load_val;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        bin_next  = bin_reg + WIDTH'(1);
        wrap_next = &bin_reg;
      end else begin
        bin_next  = bin_reg - WIDTH'(1);
        wrap_next = ~|bin_reg;
      end
    end
    gray_next = bin_next ^ (bin_next >> 1);
  end

  // Binary and Gray views are loaded from the same next value on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_reg  <= '0;
      gray_reg <= '0;
      wrap_reg <= 1'b0;
    end else begin
      bin_reg  <= bin_next;
      gray_reg <= gray_next;
      wrap_reg <= wrap_next;
    end
  end

  // More than one bit set in the diff <=> clearing the lowest set bit leaves something.
  always_comb begin
    step_diff = bus.gray_in ^ prev_reg;
    multi_bit = |(step_diff & (step_diff - WIDTH'(1)));
  end

  // Monitor: decode and step check on valid samples; gaps keep prev/have_prev.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_reg      <= '0;
      have_prev_reg <= 1'b0;
      dec_reg       <= '0;
      dec_vld_reg   <= 1'b0;
      step_err_reg  <= 1'b0;
    end else if (bus.gray_in_vld) begin
      dec_reg       <= in_dec;
      dec_vld_reg   <= 1'b1;
      step_err_reg  <= have_prev_reg & multi_bit;
      prev_reg      <= bus.gray_in;
      have_prev_reg <= 1'b1;
    end else begin
      dec_vld_reg   <= 1'b0;
      step_err_reg  <= 1'b0;
    end
  end

  assign bus.bin_q       = bin_reg;
  assign bus.gray_q      = gray_reg;
  assign bus.wrap        = wrap_reg;
  assign bus.bin_dec     = dec_reg;
  assign bus.bin_dec_vld = dec_vld_reg;
  assign bus.step_err    = step_err_reg;

endmodule
